// File: rtl/vga_text_pkg.sv
// vga_text_pkg: default text-mode geometry, derived widths and fetch FSM states
package vga_text_pkg;

    localparam int COLUMNS_DEF = 80;
    localparam int ROWS_DEF    = 30;
    localparam int PIXELS_DEF  = 10;
    localparam int LINES_DEF   = 16;
    localparam int CODE_W_DEF  = 8;

    localparam int COL_W   = $clog2(COLUMNS_DEF);
    localparam int ROW_W   = $clog2(ROWS_DEF);
    localparam int TEXT_AW = $clog2(COLUMNS_DEF * ROWS_DEF);
    localparam int FONT_AW = CODE_W_DEF + $clog2(LINES_DEF);

    typedef enum logic [1:0] {IDLE, TEXT, FONT, LATCH} fetch_state_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: ce-gated DEPTH-stage shift register with a loadable reset value
module vga_delay_line #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH*WIDTH-1:0] sr;

    // newest sample enters at the bottom, oldest leaves at the top
    always_ff @(posedge clk or posedge reset)
        if (reset) sr <= {DEPTH{rst_val}};
        else if (ce) sr <= {sr[(DEPTH-1)*WIDTH-1:0], d};

    assign q = sr[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/vga_text_fetch.sv
// vga_text_fetch: text-mode scanout, fetches char/font ahead of the beam (cursor via VGA_TEXT_CURSOR_EN)
module vga_text_fetch
    import vga_text_pkg::*;
#(
    parameter int COLUMNS    = COLUMNS_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int PIXELS     = PIXELS_DEF,
    parameter int LINES      = LINES_DEF,
    parameter int CODE_WIDTH = CODE_W_DEF
`ifdef VGA_TEXT_CURSOR_EN
    , parameter int CURSOR_TOP = LINES - 2
`endif
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     ce,
    input  logic                                     h_active,
    input  logic [$clog2(COLUMNS)-1:0]               h_glyph,
    input  logic [$clog2(PIXELS)-1:0]                h_pixel,
    input  logic                                     h_sync,
    input  logic                                     v_active,
    input  logic [$clog2(ROWS)-1:0]                  v_glyph,
    input  logic [$clog2(LINES)-1:0]                 v_pixel,
    input  logic                                     v_sync,
`ifdef VGA_TEXT_CURSOR_EN
    input  logic                                     cursor_show,
    input  logic [$clog2(COLUMNS)-1:0]               cursor_col,
    input  logic [$clog2(ROWS)-1:0]                  cursor_row,
`endif
    output logic [$clog2(COLUMNS*ROWS)-1:0]          text_addr,
    output logic                                     text_we,
    output logic [CODE_WIDTH-1:0]                    text_wdata,
    input  logic [CODE_WIDTH-1:0]                    text_rdata,
    output logic [CODE_WIDTH+$clog2(LINES)-1:0]      font_addr,
    input  logic [PIXELS-1:0]                        font_rdata,
    input  logic                                     cpu_valid,
    output logic                                     cpu_ready,
    input  logic [$clog2(COLUMNS*ROWS)-1:0]          cpu_addr,
    input  logic [CODE_WIDTH-1:0]                    cpu_data,
    output logic                                     pixel_on,
    output logic                                     de,
    output logic                                     hsync_d,
    output logic                                     vsync_d
);

    localparam int TAW = $clog2(COLUMNS * ROWS);
    localparam int LW  = $clog2(LINES);

    fetch_state_t      state, state_nx;
    logic              issue, h_active_q, load;
    logic [TAW-1:0]    scan_addr;
    logic [LW-1:0]     fetch_line;
    logic [PIXELS-1:0] row_bits, next_bits, shift;

    assign issue     = ce && h_active && v_active && (h_pixel == '0);
    assign scan_addr = TAW'(v_glyph) * TAW'(COLUMNS) + TAW'(h_glyph);

    // scanout owns the RAM port in the issue cycle, the CPU gets it otherwise
    assign cpu_ready  = !issue;
    assign text_addr  = issue ? scan_addr : cpu_addr;
    assign text_we    = !issue && cpu_valid;
    assign text_wdata = cpu_data;

    // fetch sequencer state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    // three clk fetch: RAM read, ROM read, latch
    always_comb begin
        state_nx = (state == IDLE) ? (issue ? TEXT : IDLE) :
                   (state == TEXT) ? FONT :
                   (state == FONT) ? LATCH : IDLE;
    end

`ifdef VGA_TEXT_CURSOR_EN
    logic [$clog2(COLUMNS)-1:0] fetch_col;
    logic [$clog2(ROWS)-1:0]    fetch_row;

    // remember which cell is in flight so the cursor test matches the fetched glyph
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            fetch_col <= '0;
            fetch_row <= '0;
        end else if (issue) begin
            fetch_col <= h_glyph;
            fetch_row <= v_glyph;
        end

    assign row_bits = font_rdata ^ {PIXELS{cursor_show && fetch_col == cursor_col &&
                                           fetch_row == cursor_row && int'(fetch_line) >= CURSOR_TOP}};
`else
    assign row_bits = font_rdata;
`endif

    // fetch pipeline registers: scanline at issue, font address, font row
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            fetch_line <= '0;
            font_addr  <= '0;
            next_bits  <= '0;
        end else begin
            if (issue) fetch_line <= v_pixel;
            if (state == TEXT) font_addr <= {text_rdata, fetch_line};
            if (state == LATCH) next_bits <= row_bits;
        end

    // previous glyph loads at the next issue, or at the first blank ce for the last column
    assign load = (issue && h_glyph != '0) || (!h_active && h_active_q);

    // pixel serialiser, MSB first
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            shift      <= '0;
            h_active_q <= 1'b0;
        end else if (ce) begin
            h_active_q <= h_active;
            shift      <= load ? next_bits : {shift[PIXELS-2:0], 1'b0};
        end

    vga_delay_line #(.DEPTH(PIXELS), .WIDTH(3)) u_delay (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .rst_val (3'b011),
        .d       ({h_active && v_active, h_sync, v_sync}),
        .q       ({de, hsync_d, vsync_d})
    );

    assign pixel_on = shift[PIXELS-1] && de;

endmodule
